// File: rtl/sd_audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sd_audio_pkg
//  Purpose  : Shared types and constants for the SD-card audio streaming path.
//             Holds the scheduler state enum and the byte sizes of one SD
//             sector and of one half of the ping-pong audio RAM.
//  Revision : 1.0 - initial release
// ============================================================================
package sd_audio_pkg;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        XFER  = 3'd2,
        CHECK = 3'd3,
        WAIT  = 3'd4,
        STOP  = 3'd5
    } sched_state_t;

    localparam int unsigned SEC_BYTES  = 512;
    localparam int unsigned HALF_BYTES = 4096;

endpackage
`default_nettype wire

// File: rtl/sd_sec_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : sd_sec_addr_gen
//  Purpose  : Holds the SD sector address sent with each read request.
//             Advances by one per completed sector. At the last sector of the
//             file it either wraps to the first sector (SD_BUF_LOOP_EN defined)
//             or holds (SD_BUF_LOOP_EN undefined; the scheduler stops).
//  Ports    : clk       in   1   system clock
//             rst_n     in   1   asynchronous active-low reset
//             i_advance in   1   current sector finished, step the address
//             o_rd_sec  out  32  current sector address
//  Config   : SD_BUF_LOOP_EN - wrap from OADDR back to SADDR
//  Revision : 1.0 - initial release
// ============================================================================
module sd_sec_addr_gen #(
    parameter logic [31:0] SADDR = 32'd32784,
    parameter logic [31:0] OADDR = 32'd15269887
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_advance,
    output logic [31:0] o_rd_sec
);

    logic [31:0] r_rd_sec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_sec <= SADDR;
        end else if (i_advance) begin
            if (r_rd_sec == OADDR) begin
`ifdef SD_BUF_LOOP_EN
                r_rd_sec <= SADDR;
`else
                // End of file: the scheduler stops, address is parked here.
                r_rd_sec <= r_rd_sec;
`endif
            end else begin
                r_rd_sec <= r_rd_sec + 32'd1;
            end
        end
    end

    assign o_rd_sec = r_rd_sec;

endmodule
`default_nettype wire

// File: rtl/sd_buf_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : sd_buf_scheduler
//  Purpose  : Sequences SD sector reads into the 8 KB ping-pong audio RAM.
//             Primes both 4 KB halves, enables playback, then refills each
//             half as the WAV reader drains it.
//  Ports    : clk_50M      in   1   system clock
//             rst_n        in   1   asynchronous active-low reset
//             start        in   1   SD init done (sampled in IDLE only)
//             rd_req       out  1   sector read request
//             rd_sec       out  32  sector address, stable while rd_req=1
//             rd_ack       in   1   request accepted (pulse)
//             sec_done     in   1   sector written to RAM (pulse)
//             wr_half      out  1   RAM half receiving data
//             half_valid   out  2   per-half full flags
//             half_drained in   2   per-half reader-finished pulses
//             play_en      out  1   playback enable (sticky once primed)
//             underrun     out  1   sticky underrun flag
//             play_end     out  1   end of file played out
//  Config   : SD_BUF_LOOP_EN - loop the file forever; play_end stays 0
//  Revision : 1.0 - initial release
// ============================================================================
module sd_buf_scheduler
    import sd_audio_pkg::*;
#(
    parameter logic [31:0] SADDR     = 32'd32784,
    parameter logic [31:0] OADDR     = 32'd15269887,
    parameter int unsigned SEC_PER_H = HALF_BYTES / SEC_BYTES
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic        start,
    output logic        rd_req,
    output logic [31:0] rd_sec,
    input  logic        rd_ack,
    input  logic        sec_done,
    output logic        wr_half,
    output logic [1:0]  half_valid,
    input  logic [1:0]  half_drained,
    output logic        play_en,
    output logic        underrun,
    output logic        play_end
);

    localparam int unsigned      c_cnt_w    = (SEC_PER_H > 1) ? $clog2(SEC_PER_H) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SEC_PER_H - 1);

    sched_state_t       r_state;
    sched_state_t       w_state_nxt;
    logic [c_cnt_w-1:0] r_sec_cnt;
    logic               r_rd_req;
    logic               r_wr_half;
    logic [1:0]         r_half_valid;
    logic               r_play_en;
    logic               r_underrun;

    logic               w_advance;
    logic               w_fill_done;
    logic               w_eof;
    logic [31:0]        w_rd_sec;
    logic [1:0]         w_drain_ok;
    logic [1:0]         w_fill_mask;
    logic               w_underrun_hit;

    sd_sec_addr_gen #(
        .SADDR (SADDR),
        .OADDR (OADDR)
    ) u_addr_gen (
        .clk       (clk_50M),
        .rst_n     (rst_n),
        .i_advance (w_advance),
        .o_rd_sec  (w_rd_sec)
    );

`ifdef SD_BUF_LOOP_EN
    assign w_eof = 1'b0;
`else
    assign w_eof = (w_rd_sec == OADDR);
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_advance   = 1'b0;
        w_fill_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = REQ;
            end
            REQ: begin
                if (rd_ack) w_state_nxt = XFER;
            end
            XFER: begin
                if (sec_done) begin
                    w_advance = 1'b1;
                    if (w_eof) begin
                        // Last file sector: publish the (possibly partial) half.
                        w_fill_done = 1'b1;
                        w_state_nxt = STOP;
                    end else if (r_sec_cnt == c_cnt_last) begin
                        w_fill_done = 1'b1;
                        w_state_nxt = CHECK;
                    end else begin
                        w_state_nxt = REQ;
                    end
                end
            end
            // r_wr_half has already toggled to the next half to fill.
            CHECK: begin
                w_state_nxt = r_half_valid[r_wr_half] ? WAIT : REQ;
            end
            WAIT: begin
                if (half_drained[r_wr_half]) w_state_nxt = REQ;
            end
            STOP: begin
                w_state_nxt = STOP;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Drain pulses only count against halves that are actually full.
    assign w_drain_ok     = half_drained & r_half_valid;
    assign w_fill_mask    = {w_fill_done & r_wr_half, w_fill_done & ~r_wr_half};
    assign w_underrun_hit = r_play_en &
                            ((w_drain_ok[0] & ~r_half_valid[1]) |
                             (w_drain_ok[1] & ~r_half_valid[0]));

    // ------------------------------------------------------------------
    // State and bookkeeping registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_sec_cnt    <= '0;
            r_rd_req     <= 1'b0;
            r_wr_half    <= 1'b0;
            r_half_valid <= 2'b00;
            r_play_en    <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            // Request rises one cycle after entering REQ, drops on accept.
            r_rd_req <= (r_state == REQ) && !rd_ack;
            if (w_advance) begin
                r_sec_cnt <= w_fill_done ? '0 : r_sec_cnt + c_cnt_w'(1);
            end
            if (w_fill_done) begin
                r_wr_half <= ~r_wr_half;
            end
            // Drain of one half and fill of the other may land together.
            r_half_valid <= (r_half_valid & ~w_drain_ok) | w_fill_mask;
            if (&r_half_valid) begin
                r_play_en <= 1'b1;
            end
            if (w_underrun_hit) begin
                r_underrun <= 1'b1;
            end
        end
    end

`ifdef SD_BUF_LOOP_EN
    assign play_end = 1'b0;
`else
    logic r_play_end;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_play_end <= 1'b0;
        end else if ((r_state == STOP) && (r_half_valid == 2'b00)) begin
            r_play_end <= 1'b1;
        end
    end

    assign play_end = r_play_end;
`endif

    assign rd_req     = r_rd_req;
    assign rd_sec     = w_rd_sec;
    assign wr_half    = r_wr_half;
    assign half_valid = r_half_valid;
    assign play_en    = r_play_en;
    assign underrun   = r_underrun;

endmodule
`default_nettype wire
